sdram_req_arbiter: RTL and testbench

- Responder side of the SDRAM request/acknowledge interface used by the capture/display FIFO controller.
- Accepts page-burst write and read requests with their 22-bit addresses, and inserts periodic auto-refresh.
- Arbitrates between refresh, write and read, and issues one command at a time to the low-level SDRAM command engine.
- Generates the per-word ack windows: sdram_wr_ack pops the write FIFO; sdram_rd_ack pushes the read FIFO. Each ack window is exactly BURST_LEN contiguous cycles, and its falling edge advances the requester's address.

---
 rtl/sdram_arb_pkg.sv | 40 ++++
 rtl/sdram_ref_timer.sv | 55 +++++
 rtl/sdram_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared encodings and defaults for the SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int BURST_LEN_DEF  = 256;
  localparam int REF_PERIOD_DEF = 1560;
  localparam int BCNT_W_DEF     = 9;

  // Command codes seen by the low-level SDRAM command engine.
  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_REF = 2'd1,
    CMD_WR  = 2'd2,
    CMD_RD  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_GO   = 3'd3,
    ST_BURST     = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  // Choose between pending data requests; with both high, take the one
  // not served last so neither FIFO can starve the other.
  function automatic cmd_t pick_data_cmd(input logic wr_req, input logic rd_req,
                                         input cmd_t last_grant);
    cmd_t sel;
    if (wr_req && rd_req) begin
      sel = (last_grant == CMD_WR) ? CMD_RD : CMD_WR;
    end else if (wr_req) begin
      sel = CMD_WR;
    end else begin
      sel = CMD_RD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator with a sticky overrun flag.
module sdram_ref_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic clk_100m,
  input  logic rst,
  input  logic enable,
  input  logic ref_ack,
  output logic ref_pending,
  output logic ref_overrun
);

  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             pending_r;
  logic             overrun_r;
  logic             tick_s;

  assign tick_s      = enable && (cnt_r == CNT_W'(REF_PERIOD - 1));
  assign ref_pending = pending_r;
  assign ref_overrun = overrun_r;

  // Refresh interval counter; only runs once the SDRAM has been initialised.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // A new tick wins over a same-cycle acknowledge so no interval is lost;
  // a tick landing on an unserved request is recorded as an overrun.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (tick_s) begin
        pending_r <= 1'b1;
      end else if (ref_ack) begin
        pending_r <= 1'b0;
      end
      if (tick_s && pending_r) begin
        overrun_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates refresh, write and read bursts towards the SDRAM command engine
// and produces the per-word FIFO ack windows.
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int BCNT_W     = BCNT_W_DEF
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        init_done,
  input  logic        sdram_wr_req,
  input  logic        sdram_rd_req,
  input  logic [21:0] sys_wraddr,
  input  logic [21:0] sys_rdaddr,
  output logic        sdram_wr_ack,
  output logic        sdram_rd_ack,
  output logic        cmd_start,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_type,
  output logic [21:0] cmd_addr,
  input  logic        data_go,
  output logic        burst_stop,
  input  logic        cmd_done,
  output logic        ref_overrun,
  output logic        busy
);

  state_t             state_r, state_nxt_s;
  cmd_t               cmd_type_r, cmd_type_nxt_s;
  cmd_t               last_grant_r, last_grant_nxt_s;
  logic [21:0]        cmd_addr_r, cmd_addr_nxt_s;
  logic [BCNT_W-1:0]  bcnt_r, bcnt_nxt_s;
  logic               cmd_start_r, wr_ack_r, rd_ack_r, burst_stop_r, busy_r;
  logic               ref_pending_s, ref_ack_s;

  assign ref_ack_s = (state_r == ST_ISSUE) && (cmd_type_r == CMD_REF) && cmd_ready;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk_100m    (clk_100m),
    .rst         (rst),
    .enable      (init_done),
    .ref_ack     (ref_ack_s),
    .ref_pending (ref_pending_s),
    .ref_overrun (ref_overrun)
  );

  // Next-state, grant and beat-count decisions.
  always_comb begin
    state_nxt_s      = state_r;
    cmd_type_nxt_s   = cmd_type_r;
    cmd_addr_nxt_s   = cmd_addr_r;
    last_grant_nxt_s = last_grant_r;
    bcnt_nxt_s       = bcnt_r;
    case (state_r)
      ST_INIT_WAIT: begin
        if (init_done) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INIT_WAIT;
        end
      end
      ST_IDLE: begin
        if (ref_pending_s) begin
          cmd_type_nxt_s = CMD_REF;
          state_nxt_s    = ST_ISSUE;
        end else if (sdram_wr_req || sdram_rd_req) begin
          cmd_type_nxt_s   = pick_data_cmd(sdram_wr_req, sdram_rd_req, last_grant_r);
          cmd_addr_nxt_s   = (cmd_type_nxt_s == CMD_WR) ? sys_wraddr : sys_rdaddr;
          last_grant_nxt_s = cmd_type_nxt_s;
          state_nxt_s      = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!cmd_ready) begin
          state_nxt_s = ST_ISSUE;
        end else if (cmd_type_r == CMD_REF) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          state_nxt_s = ST_WAIT_GO;
        end
      end
      ST_WAIT_GO: begin
        if (data_go) begin
          state_nxt_s = ST_BURST;
          bcnt_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_WAIT_GO;
        end
      end
      ST_BURST: begin
        if (bcnt_r == BCNT_W'(BURST_LEN - 1)) begin
          state_nxt_s = ST_WAIT_DONE;
        end else begin
          bcnt_nxt_s = bcnt_r + BCNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (cmd_done) begin
          state_nxt_s    = ST_IDLE;
          cmd_type_nxt_s = CMD_NOP;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s    = ST_INIT_WAIT;
        cmd_type_nxt_s = CMD_NOP;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state_r      <= ST_INIT_WAIT;
      cmd_type_r   <= CMD_NOP;
      last_grant_r <= CMD_RD;
      cmd_addr_r   <= 22'd0;
      bcnt_r       <= '0;
      cmd_start_r  <= 1'b0;
      wr_ack_r     <= 1'b0;
      rd_ack_r     <= 1'b0;
      burst_stop_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cmd_type_r   <= cmd_type_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      cmd_addr_r   <= cmd_addr_nxt_s;
      bcnt_r       <= bcnt_nxt_s;
      cmd_start_r  <= (state_nxt_s == ST_ISSUE);
      wr_ack_r     <= (state_nxt_s == ST_BURST) && (cmd_type_nxt_s == CMD_WR);
      rd_ack_r     <= (state_nxt_s == ST_BURST) && (cmd_type_nxt_s == CMD_RD);
      burst_stop_r <= (state_nxt_s == ST_BURST) && (bcnt_nxt_s == BCNT_W'(BURST_LEN - 1));
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign cmd_start    = cmd_start_r;
  assign cmd_type     = cmd_type_r;
  assign cmd_addr     = cmd_addr_r;
  assign sdram_wr_ack = wr_ack_r;
  assign sdram_rd_ack = rd_ack_r;
  assign burst_stop   = burst_stop_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench: emulates the command engine and the FIFO requesters,
// predicting grants, ack windows and refresh/overrun from a behavioural model.
module tb_sdram_req_arbiter;

  localparam int BL    = 256;
  localparam int REF_P = 300;

  logic        clk_100m = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        sdram_wr_req = 1'b0;
  logic        sdram_rd_req = 1'b0;
  logic [21:0] sys_wraddr = 22'd0;
  logic [21:0] sys_rdaddr = 22'd0;
  logic        cmd_ready = 1'b0;
  logic        data_go = 1'b0;
  logic        cmd_done = 1'b0;
  logic        sdram_wr_ack, sdram_rd_ack, cmd_start, burst_stop, ref_overrun, busy;
  logic [1:0]  cmd_type;
  logic [21:0] cmd_addr;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  int          m_en   = 0;      // enabled cycles since reset
  logic        m_pend = 1'b0;   // refresh owed
  logic        m_ovr  = 1'b0;   // refresh interval lost
  logic [1:0]  m_last = 2'd3;   // last data grant
  logic [21:0] m_addr = 22'd0;  // last latched address

  sdram_req_arbiter #(.BURST_LEN(BL), .REF_PERIOD(REF_P), .BCNT_W(9)) dut (
    .clk_100m(clk_100m), .rst(rst), .init_done(init_done),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sys_wraddr(sys_wraddr), .sys_rdaddr(sys_rdaddr),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .cmd_start(cmd_start), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .data_go(data_go), .burst_stop(burst_stop),
    .cmd_done(cmd_done), .ref_overrun(ref_overrun), .busy(busy)
  );

  always #5 clk_100m = ~clk_100m;

  // Refresh model: a tick every REF_P enabled cycles, owed until a REFRESH handshake.
  always @(posedge clk_100m) begin
    if (rst) begin
      m_en   <= 0;
      m_pend <= 1'b0;
      m_ovr  <= 1'b0;
    end else begin
      if (init_done && (((m_en + 1) % REF_P) == 0)) begin
        m_pend <= 1'b1;
        if (m_pend) m_ovr <= 1'b1;
      end else if (cmd_start && cmd_type == 2'd1 && cmd_ready) begin
        m_pend <= 1'b0;
      end
      if (init_done) m_en <= m_en + 1;
    end
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  // Serve one command end to end as the engine would; optionally reset mid-burst.
  task automatic do_cmd(input int stall, input int rst_beat, output logic [1:0] got,
                        output int waited);
    logic [1:0]  exp_t;
    logic [21:0] exp_a, snap_wa, snap_ra;
    logic        snap_wr, snap_rd, snap_pend;
    logic [2:0]  exp3;
    int          d;
    got = 2'd0;
    waited = 0;
    do begin
      snap_wr = sdram_wr_req; snap_rd = sdram_rd_req; snap_pend = m_pend;
      snap_wa = sys_wraddr;   snap_ra = sys_rdaddr;
      tick();
      waited++;
    end while (cmd_start !== 1'b1 && waited < 2 * REF_P + 20);
    n_checks++;
    if (cmd_start !== 1'b1) begin
      n_errs++;
      $display("FAIL grant_timeout cmd_start=%b expected 1 within %0d cycles", cmd_start, waited);
      return;
    end
    if (snap_pend) begin
      exp_t = 2'd1;
      exp_a = m_addr;
    end else begin
      if (snap_wr && snap_rd) exp_t = (m_last == 2'd2) ? 2'd3 : 2'd2;
      else if (snap_wr)       exp_t = 2'd2;
      else                    exp_t = 2'd3;
      exp_a  = (exp_t == 2'd2) ? snap_wa : snap_ra;
      m_last = exp_t;
    end
    m_addr = exp_a;
    got = cmd_type;
    n_checks++;
    if (cmd_type !== exp_t || cmd_addr !== exp_a) begin
      n_errs++;
      $display("FAIL grant type=%0d addr=%h expected type=%0d addr=%h", cmd_type, cmd_addr, exp_t, exp_a);
    end
    sys_wraddr = 22'($urandom);
    sys_rdaddr = 22'($urandom);
    for (int i = 0; i < stall; i++) begin
      tick();
      n_checks++;
      if (cmd_start !== 1'b1 || cmd_addr !== exp_a) begin
        n_errs++;
        $display("FAIL start_hold cmd_start=%b addr=%h expected 1 addr=%h", cmd_start, cmd_addr, exp_a);
      end
    end
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    n_checks++;
    if (cmd_start !== 1'b0) begin
      n_errs++;
      $display("FAIL start_drop cmd_start=%b expected 0", cmd_start);
    end
    if (exp_t == 2'd1) begin
      data_go = 1'b1; tick(); data_go = 1'b0;
      n_checks++;
      if ({sdram_wr_ack, sdram_rd_ack} !== 2'b00) begin
        n_errs++;
        $display("FAIL stray_go acks=%b expected 00", {sdram_wr_ack, sdram_rd_ack});
      end
    end else begin
      cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      n_checks++;
      if ({sdram_wr_ack, sdram_rd_ack, busy} !== 3'b001) begin
        n_errs++;
        $display("FAIL stray_done acks_busy=%b expected 001", {sdram_wr_ack, sdram_rd_ack, busy});
      end
      d = $urandom_range(0, 3);
      repeat (d) tick();
      data_go = 1'b1; tick(); data_go = 1'b0;
      for (int i = 0; i < BL; i++) begin
        exp3 = {(exp_t == 2'd2), (exp_t == 2'd3), (i == BL - 1)};
        n_checks++;
        if ({sdram_wr_ack, sdram_rd_ack, burst_stop} !== exp3) begin
          n_errs++;
          $display("FAIL beat%0d wr_rd_stop=%b expected %b", i, {sdram_wr_ack, sdram_rd_ack, burst_stop}, exp3);
        end
        if (i == rst_beat) begin
          rst = 1'b1; init_done = 1'b0; tick(); rst = 1'b0;
          m_last = 2'd3; m_addr = 22'd0;
          n_checks++;
          if ({sdram_wr_ack, sdram_rd_ack, burst_stop, cmd_start, busy, ref_overrun} !== 6'd0 ||
              cmd_type !== 2'd0 || cmd_addr !== 22'd0) begin
            n_errs++;
            $display("FAIL mid_reset outs=%b type=%0d addr=%h expected all zero",
                     {sdram_wr_ack, sdram_rd_ack, burst_stop, cmd_start, busy, ref_overrun}, cmd_type, cmd_addr);
          end
          return;
        end
        tick();
      end
      n_checks++;
      if ({sdram_wr_ack, sdram_rd_ack, burst_stop, busy} !== 4'b0001) begin
        n_errs++;
        $display("FAIL post_burst wr_rd_stop_busy=%b expected 0001", {sdram_wr_ack, sdram_rd_ack, burst_stop, busy});
      end
    end
    d = $urandom_range(0, 3);
    repeat (d) tick();
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    n_checks++;
    if (cmd_type !== 2'd0 || busy !== 1'b0) begin
      n_errs++;
      $display("FAIL done_idle type=%0d busy=%b expected 0 0", cmd_type, busy);
    end
    n_checks++;
    if (ref_overrun !== m_ovr) begin
      n_errs++;
      $display("FAIL overrun_model ref_overrun=%b expected %b", ref_overrun, m_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({sdram_wr_ack, sdram_rd_ack, cmd_start, burst_stop, ref_overrun, busy} !== 6'd0 ||
        cmd_type !== 2'd0 || cmd_addr !== 22'd0) begin
      n_errs++;
      $display("FAIL reset outs=%b type=%0d addr=%h expected all zero",
               {sdram_wr_ack, sdram_rd_ack, cmd_start, burst_stop, ref_overrun, busy}, cmd_type, cmd_addr);
    end
    rst = 1'b0; m_last = 2'd3; m_addr = 22'd0;
  endtask

  task automatic test_init_wait();
    logic [1:0] got;
    int w;
    sdram_wr_req = 1'b1;
    sys_wraddr = 22'($urandom);
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if ({cmd_start, sdram_wr_ack, sdram_rd_ack, busy} !== 4'b0001) begin
        n_errs++;
        $display("FAIL init_wait%0d start_wr_rd_busy=%b expected 0001", i, {cmd_start, sdram_wr_ack, sdram_rd_ack, busy});
      end
    end
    init_done = 1'b1;
    tick();
    n_checks++;
    if (cmd_start !== 1'b0) begin
      n_errs++;
      $display("FAIL init_first cmd_start=%b expected 0", cmd_start);
    end
    do_cmd(1, -1, got, w);
    n_checks++;
    if (got !== 2'd2 || w !== 1) begin
      n_errs++;
      $display("FAIL init_grant type=%0d wait=%0d expected 2 1", got, w);
    end
  endtask

  task automatic test_single_write();
    logic [1:0] got;
    int w;
    sdram_wr_req = 1'b1; sdram_rd_req = 1'b0;
    sys_wraddr = 22'h000100;
    do_cmd(0, -1, got, w);
    n_checks++;
    if (got !== 2'd2 || m_addr !== 22'h000100) begin
      n_errs++;
      $display("FAIL single_write type=%0d addr=%h expected 2 000100", got, m_addr);
    end
    sdram_wr_req = 1'b0;
  endtask

  task automatic test_alternate();
    logic [1:0] got;
    logic [1:0] exp_seq;
    int w, ndata;
    sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    m_last = 2'd3; m_addr = 22'd0;
    sdram_wr_req = 1'b1; sdram_rd_req = 1'b1;
    ndata = 0;
    for (int k = 0; k < 10 && ndata < 4; k++) begin
      do_cmd($urandom_range(0, 3), -1, got, w);
      if (got != 2'd1) begin
        exp_seq = (ndata % 2 == 0) ? 2'd2 : 2'd3;
        n_checks++;
        if (got !== exp_seq) begin
          n_errs++;
          $display("FAIL alternate%0d type=%0d expected %0d", ndata, got, exp_seq);
        end
        ndata++;
      end
    end
    sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
  endtask

  task automatic test_refresh_mid_burst();
    logic [1:0] got;
    int w, n;
    sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
    n = 0;
    while (n < 4 * REF_P) begin
      if (m_pend) do_cmd(0, -1, got, w);
      else if (REF_P - (m_en % REF_P) == 100) break;
      else tick();
      n++;
    end
    sdram_rd_req = 1'b1;
    do_cmd($urandom_range(0, 3), -1, got, w);
    n_checks++;
    if (got !== 2'd3) begin
      n_errs++;
      $display("FAIL mid_read type=%0d expected 3", got);
    end
    sdram_rd_req = 1'b0; sdram_wr_req = 1'b1;
    do_cmd(0, -1, got, w);
    n_checks++;
    if (got !== 2'd1) begin
      n_errs++;
      $display("FAIL ref_first type=%0d expected 1", got);
    end
    do_cmd(0, -1, got, w);
    n_checks++;
    if (got !== 2'd2) begin
      n_errs++;
      $display("FAIL write_after_ref type=%0d expected 2", got);
    end
    sdram_wr_req = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] got;
    int w;
    for (int k = 0; k < 6; k++) begin
      sdram_wr_req = 1'($urandom_range(0, 1));
      sdram_rd_req = 1'($urandom_range(0, 1));
      if (!sdram_wr_req && !sdram_rd_req) sdram_wr_req = 1'b1;
      sys_wraddr = 22'($urandom);
      sys_rdaddr = 22'($urandom);
      do_cmd($urandom_range(0, 3), -1, got, w);
    end
    sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
  endtask

  task automatic test_overrun();
    logic [1:0] got;
    int w;
    sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
    do_cmd(REF_P + 40, -1, got, w);
    n_checks++;
    if (got !== 2'd1 || ref_overrun !== 1'b1) begin
      n_errs++;
      $display("FAIL overrun type=%0d ref_overrun=%b expected 1 1", got, ref_overrun);
    end
    do_cmd(0, -1, got, w);
    n_checks++;
    if (got !== 2'd1 || ref_overrun !== 1'b1) begin
      n_errs++;
      $display("FAIL overrun_sticky type=%0d ref_overrun=%b expected 1 1", got, ref_overrun);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] got;
    int w;
    sdram_wr_req = 1'b1; sdram_rd_req = 1'b0;
    do_cmd(0, 100, got, w);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({cmd_start, sdram_wr_ack, busy} !== 3'b001) begin
        n_errs++;
        $display("FAIL back_in_init start_ack_busy=%b expected 001", {cmd_start, sdram_wr_ack, busy});
      end
    end
    init_done = 1'b1;
    do_cmd(0, -1, got, w);
    n_checks++;
    if (got !== 2'd2 || w !== 2) begin
      n_errs++;
      $display("FAIL reinit_grant type=%0d wait=%0d expected 2 2", got, w);
    end
    sdram_wr_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_wait();
    test_single_write();
    test_alternate();
    test_refresh_mid_burst();
    test_random();
    test_overrun();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
